// File: rtl/hovalaag_io_bridge_pkg.sv
// Shared word width and port-select encodings for the Hovalaag host I/O bridge.
package hovalaag_io_bridge_pkg;
    localparam int   WORD_W    = 12;
    localparam logic SEL_PORT1 = 1'b0;
    localparam logic SEL_PORT2 = 1'b1;
endpackage

// File: rtl/hovalaag_io_bridge_fifo.sv
// Generic FIFO: head is presented combinationally from storage, pop takes effect at the edge.
// Latency: a pushed word becomes visible at the head one edge after the push.
// Backpressure: none inside; the caller gates push/pop using full/empty.
module hovalaag_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Storage carries no reset; empty gating of the head hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign empty = (level == '0);
    assign full  = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/hovalaag_io_bridge.sv
// Host-side bridge for the Hovalaag CPU: two input FIFOs feed IN1/IN2, two output FIFOs catch OUT.
// Latency: zero-cycle head presentation, one-edge push/pop; sticky underflow/overflow flags.
// Backpressure: host writes stall on full input FIFO; CPU output is never stalled (drops when full).
module hovalaag_io_bridge
    import hovalaag_io_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_wr_valid,
    input  logic                  in_wr_sel,
    input  logic [WORD_W-1:0]     in_wr_data,
    output logic                  in_wr_ready,
    output logic [WORD_W-1:0]     cpu_in1,
    input  logic                  cpu_in1_adv,
    output logic [WORD_W-1:0]     cpu_in2,
    input  logic                  cpu_in2_adv,
    input  logic [WORD_W-1:0]     cpu_out,
    input  logic                  cpu_out_valid,
    input  logic                  cpu_out_select,
    output logic                  out1_valid,
    output logic [WORD_W-1:0]     out1_data,
    input  logic                  out1_ready,
    output logic                  out2_valid,
    output logic [WORD_W-1:0]     out2_data,
    input  logic                  out2_ready,
    output logic [DEPTH_LOG2:0]   in1_level,
    output logic [DEPTH_LOG2:0]   in2_level,
    output logic [DEPTH_LOG2:0]   out1_level,
    output logic [DEPTH_LOG2:0]   out2_level,
    input  logic                  clear_err,
    output logic                  err_underflow,
    output logic                  err_overflow
);
    logic in1_full, in1_empty, in2_full, in2_empty;
    logic out1_full, out1_empty, out2_full, out2_empty;
    logic in1_push, in2_push, in1_pop, in2_pop;
    logic out1_push, out2_push, out1_pop, out2_pop;
    logic out1_cap, out2_cap;
    logic underflow_evt, overflow_evt;

    assign in_wr_ready = (in_wr_sel == SEL_PORT2) ? !in2_full : !in1_full;
    assign in1_push    = in_wr_valid && (in_wr_sel == SEL_PORT1) && !in1_full;
    assign in2_push    = in_wr_valid && (in_wr_sel == SEL_PORT2) && !in2_full;
    assign in1_pop     = cpu_in1_adv && !in1_empty;
    assign in2_pop     = cpu_in2_adv && !in2_empty;

    assign out1_valid  = !out1_empty;
    assign out2_valid  = !out2_empty;
    assign out1_pop    = out1_valid && out1_ready;
    assign out2_pop    = out2_valid && out2_ready;
    assign out1_cap    = cpu_out_valid && (cpu_out_select == SEL_PORT1);
    assign out2_cap    = cpu_out_valid && (cpu_out_select == SEL_PORT2);
    // A full output FIFO still accepts when the host frees a slot at the same edge.
    assign out1_push   = out1_cap && (!out1_full || out1_pop);
    assign out2_push   = out2_cap && (!out2_full || out2_pop);

    assign underflow_evt = (cpu_in1_adv && in1_empty) || (cpu_in2_adv && in2_empty);
    assign overflow_evt  = (out1_cap && !out1_push) || (out2_cap && !out2_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (underflow_evt)  err_underflow <= 1'b1;
            else if (clear_err) err_underflow <= 1'b0;
            if (overflow_evt)   err_overflow  <= 1'b1;
            else if (clear_err) err_overflow  <= 1'b0;
        end
    end

    hovalaag_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_in1 (
        .clk(clk), .rst_n(rst_n), .push(in1_push), .push_data(in_wr_data), .pop(in1_pop),
        .head(cpu_in1), .level(in1_level), .full(in1_full), .empty(in1_empty));

    hovalaag_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_in2 (
        .clk(clk), .rst_n(rst_n), .push(in2_push), .push_data(in_wr_data), .pop(in2_pop),
        .head(cpu_in2), .level(in2_level), .full(in2_full), .empty(in2_empty));

    hovalaag_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_out1 (
        .clk(clk), .rst_n(rst_n), .push(out1_push), .push_data(cpu_out), .pop(out1_pop),
        .head(out1_data), .level(out1_level), .full(out1_full), .empty(out1_empty));

    hovalaag_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_out2 (
        .clk(clk), .rst_n(rst_n), .push(out2_push), .push_data(cpu_out), .pop(out2_pop),
        .head(out2_data), .level(out2_level), .full(out2_full), .empty(out2_empty));
endmodule

// File: tb/tb_hovalaag_io_bridge.sv
// Scoreboard bench for hovalaag_io_bridge: expected words queued at stimulus, compared at consumption.
module tb_hovalaag_io_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_wr_valid, in_wr_sel, in_wr_ready;
    logic [11:0] in_wr_data;
    logic [11:0] cpu_in1, cpu_in2, cpu_out;
    logic        cpu_in1_adv, cpu_in2_adv, cpu_out_valid, cpu_out_select;
    logic        out1_valid, out2_valid, out1_ready, out2_ready;
    logic [11:0] out1_data, out2_data;
    logic [4:0]  in1_level, in2_level, out1_level, out2_level;
    logic        clear_err, err_underflow, err_overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_in1[$], exp_in2[$], exp_out1[$], exp_out2[$];
    logic [11:0] exp_w;

    hovalaag_io_bridge #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_wr_valid(in_wr_valid), .in_wr_sel(in_wr_sel), .in_wr_data(in_wr_data),
        .in_wr_ready(in_wr_ready),
        .cpu_in1(cpu_in1), .cpu_in1_adv(cpu_in1_adv), .cpu_in2(cpu_in2), .cpu_in2_adv(cpu_in2_adv),
        .cpu_out(cpu_out), .cpu_out_valid(cpu_out_valid), .cpu_out_select(cpu_out_select),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_data(out2_data), .out2_ready(out2_ready),
        .in1_level(in1_level), .in2_level(in2_level), .out1_level(out1_level), .out2_level(out2_level),
        .clear_err(clear_err), .err_underflow(err_underflow), .err_overflow(err_overflow));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_wr_valid = 0; in_wr_sel = 0; in_wr_data = '0;
        cpu_in1_adv = 0; cpu_in2_adv = 0;
        cpu_out_valid = 0; cpu_out_select = 0; cpu_out = '0;
        out1_ready = 0; out2_ready = 0; clear_err = 0;
    endtask

    task automatic host_push(input logic sel, input logic [11:0] d);
        in_wr_valid = 1; in_wr_sel = sel; in_wr_data = d;
        step();
        in_wr_valid = 0;
        if (sel) exp_in2.push_back(d); else exp_in1.push_back(d);
    endtask

    task automatic cpu_capture(input logic sel, input logic [11:0] d);
        cpu_out_valid = 1; cpu_out_select = sel; cpu_out = d;
        step();
        cpu_out_valid = 0;
        if (sel) exp_out2.push_back(d); else exp_out1.push_back(d);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; #3; rst_n = 1;
        step();
        host_push(0, 12'h111); host_push(0, 12'h222);
        cpu_capture(0, 12'h333);
        cpu_in2_adv = 1; step(); cpu_in2_adv = 0;
        #2; rst_n = 0; #1;
        exp_in1.delete(); exp_in2.delete(); exp_out1.delete(); exp_out2.delete();
        vectors++;
        if (in1_level !== 5'd0 || in2_level !== 5'd0 || out1_level !== 5'd0 || out2_level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_levels: got %0d/%0d/%0d/%0d want all 0", in1_level, in2_level, out1_level, out2_level);
        end
        vectors++;
        if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got uf=%b of=%b want 0 0", err_underflow, err_overflow);
        end
        vectors++;
        if (cpu_in1 !== 12'h000 || out1_valid !== 1'b0 || in_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: got cpu_in1=%h out1_valid=%b ready=%b want 000 0 1", cpu_in1, out1_valid, in_wr_ready);
        end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_in_fifo();
        host_push(0, 12'h123); host_push(0, 12'h456);
        vectors++;
        if (in1_level !== 5'd2) begin
            miscompares++; $display("FAIL in1_level_2: got %0d want 2", in1_level);
        end
        for (int k = 0; k < 2; k++) begin
            cpu_in1_adv = 1;
            exp_w = exp_in1.pop_front();
            vectors++;
            if (cpu_in1 !== exp_w) begin
                miscompares++; $display("FAIL in1_head_%0d: got %h want %h", k, cpu_in1, exp_w);
            end
            step();
            cpu_in1_adv = 0;
            vectors++;
            if (in1_level !== 5'(1 - k)) begin
                miscompares++; $display("FAIL in1_level_pop_%0d: got %0d want %0d", k, in1_level, 1 - k);
            end
        end
        vectors++;
        if (cpu_in1 !== 12'h000 || err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL in1_drained: got head=%h uf=%b want 000 0", cpu_in1, err_underflow);
        end
    endtask

    task automatic test_back_to_back();
        host_push(0, 12'hA01);
        in_wr_valid = 1; in_wr_sel = 0; in_wr_data = 12'hA02; cpu_in1_adv = 1;
        exp_w = exp_in1.pop_front();
        vectors++;
        if (cpu_in1 !== exp_w) begin
            miscompares++; $display("FAIL b2b_head: got %h want %h", cpu_in1, exp_w);
        end
        step();
        exp_in1.push_back(12'hA02);
        in_wr_valid = 0; cpu_in1_adv = 0;
        vectors++;
        if (in1_level !== 5'd1 || cpu_in1 !== exp_in1[0]) begin
            miscompares++; $display("FAIL b2b_after: got level=%0d head=%h want 1 %h", in1_level, cpu_in1, exp_in1[0]);
        end
        cpu_in1_adv = 1; void'(exp_in1.pop_front()); step(); cpu_in1_adv = 0;
    endtask

    task automatic test_underflow();
        in_wr_valid = 1; in_wr_sel = 1; in_wr_data = 12'h7FF; cpu_in2_adv = 1;
        vectors++;
        if (cpu_in2 !== 12'h000) begin
            miscompares++; $display("FAIL uf_empty_head: got %h want 000", cpu_in2);
        end
        step();
        exp_in2.push_back(12'h7FF);
        in_wr_valid = 0; cpu_in2_adv = 0;
        vectors++;
        if (err_underflow !== 1'b1 || in2_level !== 5'd1 || cpu_in2 !== exp_in2[0]) begin
            miscompares++;
            $display("FAIL uf_set: got uf=%b level=%0d head=%h want 1 1 %h", err_underflow, in2_level, cpu_in2, exp_in2[0]);
        end
        clear_err = 1; step(); clear_err = 0;
        vectors++;
        if (err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL uf_clear: got %b want 0", err_underflow);
        end
        cpu_in2_adv = 1;
        exp_w = exp_in2.pop_front();
        vectors++;
        if (cpu_in2 !== exp_w) begin
            miscompares++; $display("FAIL in2_head: got %h want %h", cpu_in2, exp_w);
        end
        step(); cpu_in2_adv = 0;
    endtask

    task automatic test_out_order();
        logic [11:0] dat [3] = '{12'h001, 12'h002, 12'h003};
        logic        sel [3] = '{1'b0, 1'b1, 1'b0};
        int n1, n2;
        for (int i = 0; i < 3; i++) cpu_capture(sel[i], dat[i]);
        n1 = 0; n2 = 0;
        out1_ready = 1; out2_ready = 1;
        for (int k = 0; k < 8 && (out1_valid || out2_valid); k++) begin
            if (out1_valid) begin
                exp_w = (exp_out1.size() > 0) ? exp_out1.pop_front() : 12'hFFF;
                vectors++; n1++;
                if (out1_data !== exp_w) begin
                    miscompares++; $display("FAIL out1_order: got %h want %h", out1_data, exp_w);
                end
            end
            if (out2_valid) begin
                exp_w = (exp_out2.size() > 0) ? exp_out2.pop_front() : 12'hFFF;
                vectors++; n2++;
                if (out2_data !== exp_w) begin
                    miscompares++; $display("FAIL out2_order: got %h want %h", out2_data, exp_w);
                end
            end
            step();
        end
        out1_ready = 0; out2_ready = 0;
        vectors++;
        if (n1 !== 2 || n2 !== 1 || out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
            miscompares++; $display("FAIL out_counts: got out1=%0d out2=%0d want 2 1", n1, n2);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) cpu_capture(0, 12'h100 + 12'(i));
        vectors++;
        if (out1_level !== 5'd16 || err_overflow !== 1'b0) begin
            miscompares++; $display("FAIL of_fill: got level=%0d of=%b want 16 0", out1_level, err_overflow);
        end
        cpu_out_valid = 1; cpu_out_select = 0; cpu_out = 12'hABC; step(); cpu_out_valid = 0;
        vectors++;
        if (err_overflow !== 1'b1 || out1_level !== 5'd16) begin
            miscompares++; $display("FAIL of_drop: got of=%b level=%0d want 1 16", err_overflow, out1_level);
        end
        clear_err = 1; step(); clear_err = 0;
        cpu_out_valid = 1; cpu_out_select = 0; cpu_out = 12'hABC; out1_ready = 1;
        exp_w = exp_out1.pop_front();
        vectors++;
        if (out1_data !== exp_w) begin
            miscompares++; $display("FAIL of_head: got %h want %h", out1_data, exp_w);
        end
        step();
        exp_out1.push_back(12'hABC);
        cpu_out_valid = 0; out1_ready = 0;
        vectors++;
        if (err_overflow !== 1'b0 || out1_level !== 5'd16) begin
            miscompares++; $display("FAIL of_accept: got of=%b level=%0d want 0 16", err_overflow, out1_level);
        end
        out1_ready = 1;
        for (int k = 0; k < 20 && out1_valid; k++) begin
            exp_w = (exp_out1.size() > 0) ? exp_out1.pop_front() : 12'hFFF;
            vectors++;
            if (out1_data !== exp_w) begin
                miscompares++; $display("FAIL of_drain: got %h want %h", out1_data, exp_w);
            end
            step();
        end
        out1_ready = 0;
        vectors++;
        if (exp_out1.size() != 0 || out1_valid !== 1'b0) begin
            miscompares++; $display("FAIL of_empty: got left=%0d valid=%b want 0 0", exp_out1.size(), out1_valid);
        end
    endtask

    task automatic test_in_full();
        for (int i = 0; i < 16; i++) host_push(0, 12'h200 + 12'(i));
        in_wr_sel = 0; #1;
        vectors++;
        if (in_wr_ready !== 1'b0 || in1_level !== 5'd16) begin
            miscompares++; $display("FAIL full_ready_sel0: got ready=%b level=%0d want 0 16", in_wr_ready, in1_level);
        end
        in_wr_sel = 1; #1;
        vectors++;
        if (in_wr_ready !== 1'b1) begin
            miscompares++; $display("FAIL full_ready_sel1: got %b want 1", in_wr_ready);
        end
        in_wr_valid = 1; in_wr_sel = 0; in_wr_data = 12'hEEE; cpu_in1_adv = 1; #1;
        exp_w = exp_in1.pop_front();
        vectors++;
        if (in_wr_ready !== 1'b0 || cpu_in1 !== exp_w) begin
            miscompares++; $display("FAIL full_pop: got ready=%b head=%h want 0 %h", in_wr_ready, cpu_in1, exp_w);
        end
        step();
        in_wr_valid = 0; cpu_in1_adv = 0;
        vectors++;
        if (in1_level !== 5'd15 || in_wr_ready !== 1'b1) begin
            miscompares++; $display("FAIL full_after_pop: got level=%0d ready=%b want 15 1", in1_level, in_wr_ready);
        end
        cpu_in1_adv = 1;
        for (int k = 0; k < 20 && in1_level != 0; k++) begin
            exp_w = (exp_in1.size() > 0) ? exp_in1.pop_front() : 12'hFFF;
            vectors++;
            if (cpu_in1 !== exp_w) begin
                miscompares++; $display("FAIL full_drain: got %h want %h", cpu_in1, exp_w);
            end
            step();
        end
        cpu_in1_adv = 0;
        vectors++;
        if (exp_in1.size() != 0 || err_underflow !== 1'b0) begin
            miscompares++; $display("FAIL full_end: got left=%0d uf=%b want 0 0", exp_in1.size(), err_underflow);
        end
    endtask

    initial begin
        rst_n = 1;
        idle();
        test_reset();
        test_in_fifo();
        test_back_to_back();
        test_underflow();
        test_out_order();
        test_overflow();
        test_in_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
